player_input_conditioner: RTL and testbench



---
 rtl/sf_input_pkg.sv | 28 ++
 rtl/player_input_conditioner_debounce_cell.sv | 46 ++++
 rtl/player_input_conditioner.sv | 67 ++++++
 tb/tb_player_input_conditioner.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sf_input_pkg.sv
// Shared controller-word layout used by the input conditioner and the game core.
package sf_input_pkg;

    localparam int unsigned CTRL_W           = 7;
    localparam int unsigned BTN_LEFT         = 0;
    localparam int unsigned BTN_RIGHT        = 1;
    localparam int unsigned BTN_UP           = 2;
    localparam int unsigned BTN_DOWN         = 3;
    localparam int unsigned BTN_ATTACK       = 4;
    localparam int unsigned BTN_SHIELD       = 5;
    localparam int unsigned BTN_ATTACK_PULSE = 6;

    typedef struct packed {
        logic attack_pulse;
        logic shield;
        logic attack;
        logic down;
        logic up;
        logic right;
        logic left;
    } ctrl_word_t;

    // Opposing directions cancel: both pressed reads as neither.
    function automatic logic [1:0] resolve_axis(input logic neg, input logic pos);
        return {pos & ~neg, neg & ~pos};
    endfunction

endpackage

// File: rtl/player_input_conditioner_debounce_cell.sv
// Two-flop synchronizer followed by a stable-window debouncer, pressed=1 polarity.
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_l,
    input  logic raw,
    output logic stable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             stable_next;

    // Any sample matching the accepted level restarts the window.
    always_comb begin
        stable_next = stable;
        cnt_next    = '0;
        if (sync2 != stable) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_next = sync2;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            cnt    <= cnt_next;
            stable <= stable_next;
        end
    end

endmodule

// File: rtl/player_input_conditioner.sv
// Per-player front end: debounce six pins, resolve opposing directions, emit packed word.
module player_input_conditioner
    import sf_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              left_l,
    input  logic              right_l,
    input  logic              up_l,
    input  logic              down_l,
    input  logic              attack,
    input  logic              shield,
    output logic [CTRL_W-1:0] controller_inputs
);

    logic       left_s;
    logic       right_s;
    logic       up_s;
    logic       down_s;
    logic       attack_s;
    logic       shield_s;
    logic       attack_hist;
    ctrl_word_t word_next;

    // Active-low pins are inverted ahead of the synchronizer so a reset-zero flop means released.
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk(clk), .rst_l(rst_l), .raw(~left_l), .stable(left_s)
    );
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk(clk), .rst_l(rst_l), .raw(~right_l), .stable(right_s)
    );
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst_l(rst_l), .raw(~up_l), .stable(up_s)
    );
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .rst_l(rst_l), .raw(~down_l), .stable(down_s)
    );
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_attack (
        .clk(clk), .rst_l(rst_l), .raw(attack), .stable(attack_s)
    );
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_shield (
        .clk(clk), .rst_l(rst_l), .raw(shield), .stable(shield_s)
    );

    // Pulse on a stable attack rising edge; a held shield swallows it outright.
    always_comb begin
        word_next                   = '0;
        {word_next.right, word_next.left} = resolve_axis(left_s, right_s);
        {word_next.down, word_next.up}    = resolve_axis(up_s, down_s);
        word_next.attack            = attack_s;
        word_next.shield            = shield_s;
        word_next.attack_pulse      = attack_s & ~attack_hist & ~shield_s;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            attack_hist       <= 1'b0;
            controller_inputs <= '0;
        end else begin
            attack_hist       <= attack_s;
            controller_inputs <= word_next;
        end
    end

endmodule

// File: tb/tb_player_input_conditioner.sv
// Scoreboard bench: a window-based reference model queues the expected word per edge.
module tb_player_input_conditioner;

    localparam int unsigned D = 8;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       left_l = 1'b1;
    logic       right_l = 1'b1;
    logic       up_l = 1'b1;
    logic       down_l = 1'b1;
    logic       attack = 1'b0;
    logic       shield = 1'b0;
    logic [6:0] controller_inputs;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    logic [6:0] exp_q[$];

    player_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst_l(rst_l),
        .left_l(left_l), .right_l(right_l), .up_l(up_l), .down_l(down_l),
        .attack(attack), .shield(shield),
        .controller_inputs(controller_inputs)
    );

    always #5 clk = ~clk;

    // Reference model: pin samples taken at each edge; a pin's accepted level flips once the
    // D samples ending two edges back all disagree with it. Output is one edge behind that.
    bit hist[6][$];
    bit stab[6];
    bit att_prev;

    always @(posedge clk) begin
        logic [5:0] smp;
        logic [6:0] e;
        smp = {shield, attack, ~down_l, ~up_l, ~right_l, ~left_l};
        if (!rst_l) begin
            for (int p = 0; p < 6; p++) begin
                hist[p].delete();
                for (int k = 0; k < int'(D) + 2; k++) hist[p].push_back(1'b0);
                stab[p] = 1'b0;
            end
            att_prev = 1'b0;
            exp_q.push_back(7'd0);
        end else begin
            e    = '0;
            e[0] = stab[0] && !stab[1];
            e[1] = stab[1] && !stab[0];
            e[2] = stab[2] && !stab[3];
            e[3] = stab[3] && !stab[2];
            e[4] = stab[4];
            e[5] = stab[5];
            e[6] = stab[4] && !att_prev && !stab[5];
            att_prev = stab[4];
            exp_q.push_back(e);
            for (int p = 0; p < 6; p++) begin
                bit all_diff;
                int n;
                n = hist[p].size();
                all_diff = 1'b1;
                for (int j = 0; j < int'(D); j++)
                    if (hist[p][n-2-j] == stab[p]) all_diff = 1'b0;
                if (all_diff) stab[p] = ~stab[p];
                hist[p].push_back(smp[p]);
                if (hist[p].size() > int'(D) + 2) void'(hist[p].pop_front());
            end
        end
    end

    // Monitor: compare the DUT word against the queued expectation every cycle.
    initial begin
        logic [6:0] e;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (controller_inputs !== e) begin
                    errors++;
                    $display("FAIL word t=%0t got=%b exp=%b", $time, controller_inputs, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic idle();
        left_l = 1'b1; right_l = 1'b1; up_l = 1'b1; down_l = 1'b1;
        attack = 1'b0; shield = 1'b0;
    endtask

    initial begin
        // Reset with pins thrashing, then release idle.
        cyc(1);
        for (int i = 0; i < 20; i++) begin
            {left_l, right_l, up_l, down_l, attack, shield} = 6'($urandom);
            cyc(1);
        end
        idle();
        cyc(3);
        rst_l = 1'b1;
        cyc(20);

        // Clean press and release of left.
        left_l = 1'b0; cyc(20);
        left_l = 1'b1; cyc(20);

        // Bouncing attack, then settle high and release.
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) attack = ~attack;
            cyc(1);
        end
        attack = 1'b1; cyc(20);
        attack = 1'b0; cyc(20);

        // Opposing horizontal directions with up held.
        left_l = 1'b0; right_l = 1'b0; up_l = 1'b0; cyc(20);
        right_l = 1'b1; cyc(20);
        idle(); cyc(20);

        // Shield suppresses the pulse; fresh press afterwards pulses.
        shield = 1'b1; cyc(15);
        attack = 1'b1; cyc(20);
        idle(); cyc(20);
        attack = 1'b1; cyc(20);
        attack = 1'b0; cyc(20);

        // Reset mid-count with attack held throughout.
        attack = 1'b1; cyc(7);
        rst_l = 1'b0; cyc(1);
        rst_l = 1'b1; cyc(20);
        attack = 1'b0; cyc(20);

        // Random pin activity with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9, 0) == 0) left_l  = ~left_l;
            if ($urandom_range(9, 0) == 0) right_l = ~right_l;
            if ($urandom_range(9, 0) == 0) up_l    = ~up_l;
            if ($urandom_range(9, 0) == 0) down_l  = ~down_l;
            if ($urandom_range(9, 0) == 0) attack  = ~attack;
            if ($urandom_range(14, 0) == 0) shield = ~shield;
            if ($urandom_range(499, 0) == 0) rst_l = 1'b0;
            else rst_l = 1'b1;
            cyc(1);
        end
        rst_l = 1'b1;
        idle(); cyc(20);
        done = 1'b1;
    end

endmodule
